// File: rtl/axi_write_burst_pkg.sv
// axi_write_burst_pkg: shared FSM states, B response codes and beat sizing for the AXI write front end
package axi_write_burst_pkg;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [7:0] beat_bytes(input logic [2:0] size);
    return 8'(1) << size;
  endfunction
endpackage

// File: rtl/axi_write_beat_addr_gen.sv
// axi_write_beat_addr_gen: per-burst beat address/counter; 4K crossing flag only with AXI_WR_4K_BOUNDARY_CHECK_EN
module axi_write_beat_addr_gen
  import axi_write_burst_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              last
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
  , output logic            cross4k
`endif
);
  logic [2:0]       size_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  assign last = cnt_q == len_q;
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) begin
      beat_addr <= '0;
      size_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      beat_addr <= awaddr;
      size_q    <= awsize;
      len_q     <= awlen;
      cnt_q     <= '0;
    end else if (step) begin
      beat_addr <= beat_addr + ADDR_W'(beat_bytes(size_q));
      cnt_q     <= cnt_q + LEN_W'(1);
    end
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
  logic [ADDR_W-1:0] last_byte;
  assign last_byte = awaddr + ((ADDR_W'(awlen) + ADDR_W'(1)) << awsize) - ADDR_W'(1);
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) cross4k <= 1'b0;
    else if (load) cross4k <= awaddr[ADDR_W-1:12] != last_byte[ADDR_W-1:12];
`endif
endmodule

// File: rtl/axi_write_burst_ctrl.sv
// axi_write_burst_ctrl: AXI4 write front end (AW -> W beats -> B); AXI_WR_4K_BOUNDARY_CHECK_EN rejects 4K-crossing bursts
module axi_write_burst_ctrl
  import axi_write_burst_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 16,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic [ID_W-1:0]     i_awid,
  input  logic [LEN_W-1:0]    i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wlast,
  output logic                o_bvalid,
  input  logic                i_bready,
  output logic [ID_W-1:0]     o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb
);
  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic              run_q, err_q, last, illegal, aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0] beat_addr;
  axi_write_beat_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .i_reset   (i_reset),
    .load      (aw_hs),
    .step      (w_hs),
    .awaddr    (i_awaddr),
    .awlen     (i_awlen),
    .awsize    (i_awsize),
    .beat_addr (beat_addr),
    .last      (last)
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
    , .cross4k (illegal)
`endif
  );
`ifndef AXI_WR_4K_BOUNDARY_CHECK_EN
  assign illegal = 1'b0;
`endif
  // run_q keeps awready low while reset is held and until the first clock after release
  assign o_awready = run_q && state_q == IDLE;
  assign o_wready  = state_q == DATA;
  assign o_bvalid  = state_q == RESP;
  assign o_bid     = o_bvalid ? id_q : '0;
  assign o_bresp   = o_bvalid && (err_q || illegal) ? RESP_SLVERR : RESP_OKAY;
  assign aw_hs     = o_awready && i_awvalid;
  assign w_hs      = o_wready && i_wvalid;
  assign b_hs      = o_bvalid && i_bready;
  always_comb
    state_d = (state_q == IDLE && aw_hs)        ? DATA :
              (state_q == DATA && w_hs && last) ? RESP :
              (state_q == RESP && b_hs)         ? IDLE : state_q;
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      id_q        <= '0;
      err_q       <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      o_mem_we <= w_hs && !illegal;
      if (aw_hs) id_q <= i_awid;
      if (w_hs) err_q <= err_q || (i_wlast != last);
      else if (b_hs) err_q <= 1'b0;
      if (w_hs) begin
        o_mem_addr  <= beat_addr;
        o_mem_wdata <= i_wdata;
        o_mem_wstrb <= i_wstrb;
      end
    end
endmodule

// File: tb/tb_axi_write_burst_ctrl.sv
// tb_axi_write_burst_ctrl: randomized bursts checked against a queue-based write/response model
module tb_axi_write_burst_ctrl;
  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  strb;
  } wr_t;
  logic         clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_awvalid = 1'b0, o_awready;
  logic [63:0]  i_awaddr = '0;
  logic [15:0]  i_awid = '0;
  logic [7:0]   i_awlen = '0;
  logic [2:0]   i_awsize = '0;
  logic         i_wvalid = 1'b0, o_wready;
  logic [511:0] i_wdata = '0;
  logic [63:0]  i_wstrb = '0;
  logic         i_wlast = 1'b0;
  logic         o_bvalid, i_bready = 1'b0;
  logic [15:0]  o_bid;
  logic [1:0]   o_bresp;
  logic         o_mem_we;
  logic [63:0]  o_mem_addr;
  logic [511:0] o_mem_wdata;
  logic [63:0]  o_mem_wstrb;
  wr_t          exp_q[$];
  int           n_cmp = 0, n_err = 0;
  axi_write_burst_ctrl dut (
    .clk(clk), .i_reset(i_reset),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awid(i_awid),
    .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (o_mem_we) begin
      if (exp_q.size() == 0) check("spurious_we", 512'(1), 512'(0));
      else begin
        e = exp_q.pop_front();
        check("mem_addr", 512'(o_mem_addr), 512'(e.addr));
        check("mem_wdata", o_mem_wdata, e.data);
        check("mem_wstrb", 512'(o_mem_wstrb), 512'(e.strb));
      end
    end
  end
  function automatic bit crosses_4k(input logic [63:0] addr, input int len, input int size);
    bit r = 1'b0;
`ifdef AXI_WR_4K_BOUNDARY_CHECK_EN
    r = (addr >> 12) != ((addr + ((64'(len) + 64'd1) << size) - 64'd1) >> 12);
`endif
    return r;
  endfunction
  task automatic send_aw(input logic [63:0] addr, input logic [15:0] id, input int len, input int size);
    int t = 0;
    @(negedge clk);
    i_awvalid = 1'b1; i_awaddr = addr; i_awid = id; i_awlen = 8'(len); i_awsize = 3'(size);
    while (!o_awready && t < 50) begin @(negedge clk); t++; end
    check("aw_wait", 512'(t < 50), 512'(1));
    @(negedge clk);
    i_awvalid = 1'b0;
  endtask
  task automatic send_beat(input logic [63:0] addr, input int size, input int i, input bit last, input bit skip, input bit gaps);
    int t = 0;
    wr_t w;
    if (gaps) repeat ($urandom_range(2, 0)) @(negedge clk);
    for (int k = 0; k < 16; k++) w.data[k*32 +: 32] = $urandom;
    w.strb = {$urandom, $urandom};
    w.addr = addr + 64'(i) * (64'd1 << size);
    i_wvalid = 1'b1; i_wdata = w.data; i_wstrb = w.strb; i_wlast = last;
    while (!o_wready && t < 50) begin @(negedge clk); t++; end
    check("w_wait", 512'(t < 50), 512'(1));
    if (!skip) exp_q.push_back(w);
    @(negedge clk);
    i_wvalid = 1'b0; i_wlast = 1'b0;
  endtask
  // wlast is driven only on beat index `early`; early==len is a well-formed burst
  task automatic burst(input logic [63:0] addr, input logic [15:0] id, input int len, input int size,
                       input int early, input int bdelay, input bit gaps);
    int t = 0;
    bit bad = crosses_4k(addr, len, size);
    logic [1:0] resp;
    send_aw(addr, id, len, size);
    for (int i = 0; i <= len; i++) send_beat(addr, size, i, i == early, bad, gaps);
    resp = (bad || early != len) ? 2'b10 : 2'b00;
    while (!o_bvalid && t < 50) begin @(negedge clk); t++; end
    check("b_wait", 512'(t < 50), 512'(1));
    check("bid", 512'(o_bid), 512'(id));
    check("bresp", 512'(o_bresp), 512'(resp));
    check("wready_in_resp", 512'(o_wready), 512'(0));
    repeat (bdelay) begin
      @(negedge clk);
      check("bvalid_hold", 512'(o_bvalid), 512'(1));
      check("bid_hold", 512'(o_bid), 512'(id));
      check("bresp_hold", 512'(o_bresp), 512'(resp));
      check("aw_blocked", 512'(o_awready), 512'(0));
    end
    i_bready = 1'b1;
    @(negedge clk);
    i_bready = 1'b0;
    check("bvalid_drop", 512'(o_bvalid), 512'(0));
    check("awready_after_b", 512'(o_awready), 512'(1));
    check("writes_drained", 512'(exp_q.size()), 512'(0));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end
  initial begin
    int len, size, early;
    repeat (2) @(negedge clk);
    check("rst_awready", 512'(o_awready), 512'(0));
    check("rst_wready", 512'(o_wready), 512'(0));
    check("rst_bvalid", 512'(o_bvalid), 512'(0));
    check("rst_mem_we", 512'(o_mem_we), 512'(0));
    check("rst_mem_addr", 512'(o_mem_addr), 512'(0));
    i_reset = 1'b1;
    @(negedge clk);
    check("idle_awready", 512'(o_awready), 512'(1));
    check("idle_wready", 512'(o_wready), 512'(0));
    burst(64'h1000, 16'hA5A5, 0, 6, 0, 0, 1'b0);
    burst(64'h2000, 16'h0001, 3, 6, 3, 0, 1'b0);
    burst(64'h2800, 16'h0002, 3, 6, 1, 0, 1'b0);
    burst(64'h2C00, 16'h0003, 1, 6, 999, 0, 1'b0);
    burst(64'h3000, 16'h0004, 2, 6, 2, 5, 1'b0);
    send_aw(64'h4000, 16'h0005, 3, 6);
    send_beat(64'h4000, 6, 0, 1'b0, 1'b0, 1'b0);
    send_beat(64'h4000, 6, 1, 1'b0, 1'b0, 1'b0);
    #2 i_reset = 1'b0;
    #1;
    check("arst_mem_we", 512'(o_mem_we), 512'(0));
    check("arst_wready", 512'(o_wready), 512'(0));
    check("arst_awready", 512'(o_awready), 512'(0));
    check("arst_bvalid", 512'(o_bvalid), 512'(0));
    check("arst_mem_addr", 512'(o_mem_addr), 512'(0));
    check("arst_writes", 512'(exp_q.size()), 512'(0));
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("post_rst_bvalid", 512'(o_bvalid), 512'(0));
    check("post_rst_awready", 512'(o_awready), 512'(1));
    burst(64'h5000, 16'h0006, 1, 6, 1, 1, 1'b0);
    burst(64'hFFFF_FFFF_FFFF_FFC0, 16'h0007, 1, 6, 1, 0, 1'b0);
    burst(64'h0FC0, 16'h0008, 1, 6, 1, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      len  = ($urandom_range(4, 0) == 0) ? $urandom_range(15, 8) : $urandom_range(7, 0);
      size = $urandom_range(6, 0);
      case ($urandom_range(3, 0))
        2:       early = 999;
        3:       early = (len > 0) ? $urandom_range(len - 1, 0) : len;
        default: early = len;
      endcase
      burst({$urandom, $urandom}, 16'($urandom), len, size, early, $urandom_range(3, 0), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
